// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined magnitude comparator for two WIDTH-bit operands.
// It compares signed or unsigned values. The pipeline resolves one SLICE-bit
// slice per stage, starting with the MSB slice. The block also keeps a
// saturating count of unequal results.
module cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iSigned,
  input  logic             iClr,
  output logic             oValid,
  output logic             oEq,
  output logic             oLt,
  output logic             oGt,
  output logic [CNT_W-1:0] oMismatchCnt
);

  localparam int STAGES = WIDTH / SLICE;

  // Valid semantics: iValid qualifies iA/iB/iSigned in the cycle it is high.
  // There is no ready and every valid input is accepted. oValid marks the one
  // cycle, STAGES edges later, in which oEq/oLt/oGt belong to that input.
  // Bubbles keep their position and leave all three flags low.

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             hit;  // final stage is loading a valid, unequal result

  // In signed mode, flip the sign bits so that an unsigned compare orders
  // two's-complement values correctly.
  always_comb begin
    a_in          = iA;
    b_in          = iB;
    a_in[WIDTH-1] = iA[WIDTH-1] ^ iSigned;
    b_in[WIDTH-1] = iB[WIDTH-1] ^ iSigned;
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int IN_W  = WIDTH - k * SLICE;  // operand bits still to be compared
    localparam int REM_W = IN_W - SLICE;       // bits handed to the next stage

    logic [IN_W-1:0]  a_cur;
    logic [IN_W-1:0]  b_cur;
    logic             v_in;
    logic             d_in;
    logic             l_in;
    logic             g_in;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic             d_nx;
    logic             l_nx;
    logic             g_nx;

    if (k == 0) begin : g_src
      assign a_cur = a_in;
      assign b_cur = b_in;
      assign v_in  = iValid;
      assign d_in  = 1'b0;
      assign l_in  = 1'b0;
      assign g_in  = 1'b0;
    end else begin : g_src
      assign a_cur = stg[k-1].g_rem.a_q;
      assign b_cur = stg[k-1].g_rem.b_q;
      assign v_in  = stg[k-1].g_flag.v_q;
      assign d_in  = stg[k-1].g_flag.d_q;
      assign l_in  = stg[k-1].g_flag.l_q;
      assign g_in  = stg[k-1].g_flag.g_q;
    end

    // The top slice of the remaining bits decides this stage, unless an
    // earlier slice has already decided.
    assign a_sl = a_cur[IN_W-1 -: SLICE];
    assign b_sl = b_cur[IN_W-1 -: SLICE];
    assign d_nx = d_in | (a_sl != b_sl);
    assign l_nx = d_in ? l_in : (a_sl < b_sl);
    assign g_nx = d_in ? g_in : (a_sl > b_sl);

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      // Carry the uncompared low bits forward. They have no reset because
      // the valid bit travelling beside them qualifies them.
      always_ff @(posedge iClk) begin
        a_q <= a_cur[REM_W-1:0];
        b_q <= b_cur[REM_W-1:0];
      end
    end

    if (k < STAGES - 1) begin : g_flag
      logic v_q;
      logic d_q;
      logic l_q;
      logic g_q;

      // Intermediate stage: hold the decision made so far next to its valid bit.
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          v_q <= 1'b0;
          d_q <= 1'b0;
          l_q <= 1'b0;
          g_q <= 1'b0;
        end else begin
          v_q <= v_in;
          d_q <= d_nx;
          l_q <= l_nx;
          g_q <= g_nx;
        end
      end
    end else begin : g_out
      // Final stage: register the result flags. On a bubble, force all three low.
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          oValid <= 1'b0;
          oEq    <= 1'b0;
          oLt    <= 1'b0;
          oGt    <= 1'b0;
        end else begin
          oValid <= v_in;
          oEq    <= v_in & ~d_nx;
          oLt    <= v_in & l_nx;
          oGt    <= v_in & g_nx;
        end
      end

      assign hit = v_in & d_nx;
    end
  end

  // Saturating mismatch count. It updates on the same edge as the flags it
  // counts. A clear on that edge wins, so the coincident mismatch is dropped.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oMismatchCnt <= '0;
    end else if (iClr) begin
      oMismatchCnt <= '0;
    end else if (hit && (oMismatchCnt != {CNT_W{1'b1}})) begin
      oMismatchCnt <= oMismatchCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed bench for cmp_pipe. It uses three instances:
//   dut32: WIDTH=32 SLICE=8 CNT_W=4 (latency 4)
//   dut8:  WIDTH=8  SLICE=8 (latency 1)
//   dut4:  WIDTH=4  SLICE=1 (latency 4)
// Expected flags are packed as {valid, eq, lt, gt}.
module tb_cmp_pipe;

  localparam logic [3:0] BUB = 4'b0000;
  localparam logic [3:0] EQ  = 4'b1100;
  localparam logic [3:0] LT  = 4'b1010;
  localparam logic [3:0] GT  = 4'b1001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        v32, s32, clr32;
  logic [31:0] a32, b32;
  logic        ov32, oe32, ol32, og32;
  logic [3:0]  cnt32;

  logic        v8, s8, clr8;
  logic [7:0]  a8, b8;
  logic        ov8, oe8, ol8, og8;
  logic [7:0]  cnt8;

  logic        v4, s4, clr4;
  logic [3:0]  a4, b4;
  logic        ov4, oe4, ol4, og4;
  logic [7:0]  cnt4;

  // Expected flags for the inputs currently on each DUT's ports.
  logic [3:0] nx32, nx8, nx4;
  logic [3:0] exp32_q[$];
  logic [3:0] exp8_q[$];
  logic [3:0] exp4_q[$];
  int m32, m8, m4;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cycle  = 0;

  cmp_pipe #(.WIDTH(32), .SLICE(8), .CNT_W(4)) dut32 (
    .iClk(clk), .iRst_n(rst_n), .iValid(v32), .iA(a32), .iB(b32),
    .iSigned(s32), .iClr(clr32), .oValid(ov32), .oEq(oe32), .oLt(ol32),
    .oGt(og32), .oMismatchCnt(cnt32)
  );

  cmp_pipe #(.WIDTH(8), .SLICE(8), .CNT_W(8)) dut8 (
    .iClk(clk), .iRst_n(rst_n), .iValid(v8), .iA(a8), .iB(b8),
    .iSigned(s8), .iClr(clr8), .oValid(ov8), .oEq(oe8), .oLt(ol8),
    .oGt(og8), .oMismatchCnt(cnt8)
  );

  cmp_pipe #(.WIDTH(4), .SLICE(1), .CNT_W(8)) dut4 (
    .iClk(clk), .iRst_n(rst_n), .iValid(v4), .iA(a4), .iB(b4),
    .iSigned(s4), .iClr(clr4), .oValid(ov4), .oEq(oe4), .oLt(ol4),
    .oGt(og4), .oMismatchCnt(cnt4)
  );

  // Clock generator.
  always #5 clk = ~clk;

  // Watchdog timer.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cycle, obs, exp);
    end
  endtask

  // Reference model for the mismatch counter.
  function automatic int cnt_next(input int m, input logic clr, input logic [3:0] e, input int maxv);
    if (clr) return 0;
    if (e[3] && !e[2] && m < maxv) return m + 1;
    return m;
  endfunction

  // Reference compare for the 4-bit instance.
  function automatic logic [3:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib;
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    if (ia == ib) return EQ;
    if (ia < ib) return LT;
    return GT;
  endfunction

  task automatic idle();
    v32 = 1'b0; a32 = $urandom(); b32 = $urandom(); s32 = 1'($urandom_range(0, 1));
    v8 = 1'b0; a8 = 8'($urandom()); b8 = 8'($urandom()); s8 = 1'($urandom_range(0, 1));
    v4 = 1'b0; a4 = 4'($urandom()); b4 = 4'($urandom()); s4 = 1'($urandom_range(0, 1));
    clr32 = 1'b0; clr8 = 1'b0; clr4 = 1'b0;
    nx32 = BUB; nx8 = BUB; nx4 = BUB;
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] e);
    v32 = 1'b1; a32 = a; b32 = b; s32 = s; nx32 = e;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] e);
    v8 = 1'b1; a8 = a; b8 = b; s8 = s; nx8 = e;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [3:0] e);
    v4 = 1'b1; a4 = a; b4 = b; s4 = s; nx4 = e;
  endtask

  // Empty the scoreboard after a reset. Each queue is prefilled with one
  // bubble per pipeline stage beyond the first.
  task automatic reset_sb();
    exp32_q.delete(); exp8_q.delete(); exp4_q.delete();
    repeat (3) exp32_q.push_back(BUB);
    repeat (3) exp4_q.push_back(BUB);
    m32 = 0; m8 = 0; m4 = 0;
  endtask

  // Advance one clock. Score all three DUTs, then return inputs to idle.
  task automatic cyc();
    logic [3:0] e;
    logic c32, c8, c4;
    @(posedge clk);
    exp32_q.push_back(nx32); exp8_q.push_back(nx8); exp4_q.push_back(nx4);
    c32 = clr32; c8 = clr8; c4 = clr4;
    #1;
    cycle++;
    e = exp32_q.pop_front();
    check("flags32", {28'd0, ov32, oe32, ol32, og32}, {28'd0, e});
    m32 = cnt_next(m32, c32, e, 15);
    check("cnt32", {28'd0, cnt32}, 32'(m32));
    e = exp8_q.pop_front();
    check("flags8", {28'd0, ov8, oe8, ol8, og8}, {28'd0, e});
    m8 = cnt_next(m8, c8, e, 255);
    check("cnt8", {24'd0, cnt8}, 32'(m8));
    e = exp4_q.pop_front();
    check("flags4", {28'd0, ov4, oe4, ol4, og4}, {28'd0, e});
    m4 = cnt_next(m4, c4, e, 255);
    check("cnt4", {24'd0, cnt4}, 32'(m4));
    idle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags32"}, {28'd0, ov32, oe32, ol32, og32}, 32'd0);
    check({tag, "_cnt32"}, {28'd0, cnt32}, 32'd0);
    check({tag, "_flags8"}, {28'd0, ov8, oe8, ol8, og8}, 32'd0);
    check({tag, "_flags4"}, {28'd0, ov4, oe4, ol4, og4}, 32'd0);
  endtask

  initial begin
    idle();
    // Apply reset, check the reset state, then release reset between edges.
    #1 rst_n = 1'b0;
    #2 check_zero("reset_state");
    #19 rst_n = 1'b1;
    reset_sb();

    // Unsigned vectors: full match, a decision in the LSB slice, and a
    // decision in the MSB slice.
    drive32(32'h1234_5678, 32'h1234_5678, 1'b0, EQ); cyc();
    drive32(32'h1234_5679, 32'h1234_5678, 1'b0, GT); cyc();
    drive32(32'h02FF_FFFF, 32'h0300_0000, 1'b0, LT); cyc();
    // Signed versus unsigned interpretation of the same bits.
    drive32(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, LT); cyc();
    drive32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, GT); cyc();
    drive32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, LT); cyc();
    drive32(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, GT); cyc();
    drive32(32'h0000_0000, 32'h8000_0000, 1'b1, GT); cyc();
    drive32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, GT); cyc();
    // Streaming with the valid pattern 1,1,0,1.
    drive32(32'hAABB_CCDD, 32'hAABB_CCDE, 1'b0, LT); cyc();
    drive32(32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1, EQ); cyc();
    cyc();
    drive32(32'hFFFF_0000, 32'hFFFE_0000, 1'b1, GT); cyc();
    repeat (4) cyc();

    // Counter saturation at 15, with equal results mixed in.
    for (int i = 0; i < 20; i++) begin
      drive32(32'(i), 32'(i + 100), 1'b0, LT); cyc();
      if (i % 5 == 0) begin
        drive32(32'(i * 7), 32'(i * 7), 1'b1, EQ); cyc();
      end
    end
    repeat (4) cyc();
    check("cnt_sat", {28'd0, cnt32}, 32'd15);

    // Clear while idle, count two mismatches, then clear on the edge where a
    // mismatch lands.
    clr32 = 1'b1; cyc();
    drive32(32'h0000_0010, 32'h0000_0020, 1'b0, LT); cyc();
    drive32(32'h0000_0030, 32'h0000_0020, 1'b0, GT); cyc();
    repeat (4) cyc();
    check("cnt_two", {28'd0, cnt32}, 32'd2);
    drive32(32'h0000_0001, 32'h0000_0002, 1'b0, LT); cyc();
    cyc(); cyc();
    clr32 = 1'b1; cyc();
    check("cnt_clr_wins", {28'd0, cnt32}, 32'd0);
    drive32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, EQ); cyc();
    repeat (4) cyc();
    check("cnt_eq_hold", {28'd0, cnt32}, 32'd0);
    drive32(32'h0000_0005, 32'h0000_0004, 1'b1, GT); cyc();
    repeat (4) cyc();
    check("cnt_one", {28'd0, cnt32}, 32'd1);

    // Reset in the middle of a stream. Outputs must clear without an edge.
    drive32(32'h0000_0001, 32'h0000_0009, 1'b0, LT); cyc();
    drive32(32'h0000_0009, 32'h0000_0001, 1'b0, GT); cyc();
    drive32(32'h0000_0002, 32'h0000_0008, 1'b0, LT); cyc();
    drive32(32'h0000_0008, 32'h0000_0002, 1'b0, GT); cyc();
    drive32(32'h0000_0003, 32'h0000_0007, 1'b0, LT); cyc();
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    #1 rst_n = 1'b1;
    reset_sb();
    repeat (6) cyc();

    // Single-stage configuration: the result appears one edge after input.
    drive8(8'h80, 8'h7F, 1'b1, LT); cyc();
    drive8(8'h80, 8'h7F, 1'b0, GT); cyc();
    drive8(8'h3C, 8'h3C, 1'b1, EQ); cyc();
    cyc();
    drive8(8'hFF, 8'h00, 1'b1, LT); cyc();
    drive8(8'hFF, 8'h00, 1'b0, GT); cyc();
    cyc();

    // One-bit slices: every operand and sign combination, back to back.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          drive4(4'(a), 4'(b), 1'(s), ref4(4'(a), 4'(b), 1'(s))); cyc();
        end
      end
    end
    repeat (3) cyc();
    check("cnt4_sat", {24'd0, cnt4}, 32'd255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
